verinject_mem1_fault_tracker: RTL and testbench
===============================================

Name: verinject_mem1_fault_tracker

Overview:
- Persistent-fault counterpart to the memory read injector.
- Captures each bit-flip injected into a memory array, keeps flipping that bit on every later read of the same word, and retires the fault once the word is overwritten.
- Sits beside an instrumented memory: read data path goes through it, write strobe/address are tapped into it.
- Storage is a small slot array of (word address, bit offset) entries.

Parameters:
- LEFT, 0, data word left bit index
- RIGHT, 0, data word right bit index
- ADDR_LEFT, 0, address left bit index
- ADDR_RIGHT, 0, address right bit index
- MEM_LEFT, 0, memory array first index as declared
- MEM_RIGHT, 0, memory array last index as declared
- P_START, 0, first global injection index owned by this memory
- FIFO_SIZE, 4, number of fault slots (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- verinject__injector_state  in  32  global injection index for this cycle
- unmodified  in  [LEFT:RIGHT]  raw memory read data
- read_address  in  [ADDR_LEFT:ADDR_RIGHT]  address being read
- modified  out  [LEFT:RIGHT]  read data with all faults applied (combinational)
- do_write  in  1  memory write strobe this cycle
- write_address  in  [ADDR_LEFT:ADDR_RIGHT]  memory write address
- fault_count  out  $clog2(FIFO_SIZE)+1  number of valid slots (registered)
- overflow  out  1  sticky: a capture was dropped because all slots were full

Behaviour:
- Derived values:
  - word_len = |LEFT-RIGHT|+1
  - mem_len = |MEM_LEFT-MEM_RIGHT|+1
  - bits_start = min(LEFT,RIGHT)
  - mem_start = min(MEM_LEFT,MEM_RIGHT)
- In-range hit: P_START <= state < P_START + mem_len*word_len (unsigned 32-bit).
  - rel = state - P_START
  - word = mem_start + rel / word_len
  - bit = rel % word_len
- Slot contents: valid bit, word address (address width), bit offset ($clog2(word_len)+1 bits).
- Reset: all valid bits clear, fault_count=0, overflow=0; modified equals unmodified from the first cycle after reset.
- Read path (zero latency, combinational):
  - modified = unmodified XOR the OR of masks (1 << (bit+bits_start)) from every valid slot whose word equals read_address.
  - An in-range hit this cycle whose word equals read_address additionally XORs its bit in the same cycle.
  - The same-cycle XOR term applies in the hit cycle only; the stored slot takes effect from the next cycle.
- Clocked update, evaluated in this order each cycle:
  - 1) If do_write, clear every valid slot whose word equals write_address.
  - 2) If in-range hit:
    - If a valid slot (surviving step 1) holds the identical word/bit, clear it; XOR semantics mean a double flip cancels.
    - Otherwise write the entry into the lowest-index free slot, counting slots freed in step 1.
    - If no slot is free, drop the entry and set overflow.
- Simultaneous write and hit on the same word: the write retires the old faults and the new fault is stored. The injection lands after the write.
- Out-of-range state: no capture, no same-cycle flip.
- fault_count = popcount of valid bits after the update, registered.
- overflow is cleared only by reset.
- Reset asserted mid-operation: all slots cleared on that edge, regardless of a concurrent hit or write.

Test Plan:
Common config: LEFT=7, RIGHT=0, MEM 0..15, P_START=100, FIFO_SIZE=4; hit range is 100..227.
- Capture and persist: state=129 (word 3, bit 5) for one cycle, read_address=3, unmodified=0x00 -> modified=0x20 in that cycle and on every later read of addr 3; fault_count=1; read of addr 4 is unaffected.
- Write retires fault: after the above, do_write=1 with write_address=3 -> following cycle modified=0x00 for addr 3, fault_count=0. A write to addr 2 instead leaves 0x20 and count 1.
- Duplicate cancels: state=129 on two separate cycles -> fault_count goes 1 then 0. During the second hit cycle, a read of addr 3 with 0x00 returns 0x00.
- Overflow: states 100, 109, 118, 127, 136 on consecutive cycles -> fault_count=4 and overflow=1. Address 4 (state 136) is never flipped; addr 0 read of 0xFF returns 0xFE.
- Same-cycle write and hit: slot holds word 3 bit 5; do_write addr 3 with state=130 in one cycle -> next cycle addr 3 read of 0x00 returns 0x40, fault_count=1.
- Range edges and reset: state=99 and 228 -> no effect, count 0. State=227 -> word 15 bit 7 (0x80). Then reset for one cycle -> count 0, overflow 0, addr 15 read is unmodified.

Source files
------------

// File: rtl/verinject_mem1_fault_tracker.sv
// Persistent fault tracker for an instrumented memory: records injected bit-flips
// per (word, bit), re-applies them on every read of that word, retires them on write.
module verinject_mem1_fault_tracker #(
  parameter int          LEFT       = 0,
  parameter int          RIGHT      = 0,
  parameter int          ADDR_LEFT  = 0,
  parameter int          ADDR_RIGHT = 0,
  parameter int          MEM_LEFT   = 0,
  parameter int          MEM_RIGHT  = 0,
  parameter int unsigned P_START    = 0,
  parameter int          FIFO_SIZE  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [31:0]                    verinject__injector_state,
  input  logic [LEFT:RIGHT]              unmodified,
  input  logic [ADDR_LEFT:ADDR_RIGHT]    read_address,
  output logic [LEFT:RIGHT]              modified,
  input  logic                           do_write,
  input  logic [ADDR_LEFT:ADDR_RIGHT]    write_address,
  output logic [$clog2(FIFO_SIZE):0]     fault_count,
  output logic                           overflow
);

  localparam int unsigned WORD_LEN   = (LEFT >= RIGHT) ? LEFT - RIGHT + 1 : RIGHT - LEFT + 1;
  localparam int unsigned MEM_LEN    = (MEM_LEFT >= MEM_RIGHT) ? MEM_LEFT - MEM_RIGHT + 1
                                                               : MEM_RIGHT - MEM_LEFT + 1;
  localparam int unsigned BITS_START = (LEFT < RIGHT) ? LEFT : RIGHT;
  localparam int unsigned MEM_START  = (MEM_LEFT < MEM_RIGHT) ? MEM_LEFT : MEM_RIGHT;
  localparam int unsigned ADDR_W     = (ADDR_LEFT >= ADDR_RIGHT) ? ADDR_LEFT - ADDR_RIGHT + 1
                                                                 : ADDR_RIGHT - ADDR_LEFT + 1;
  localparam int unsigned BIT_W      = $clog2(WORD_LEN) + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_SIZE) + 1;
  localparam logic [31:0] SPAN       = 32'(MEM_LEN * WORD_LEN);

  logic [FIFO_SIZE-1:0] r_valid;
  logic [ADDR_W-1:0]    r_word [FIFO_SIZE];
  logic [BIT_W-1:0]     r_bit  [FIFO_SIZE];
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;

  logic [31:0]          w_rel;
  logic                 w_hit;
  logic [ADDR_W-1:0]    w_hit_word;
  logic [BIT_W-1:0]     w_hit_bit;
  logic [WORD_LEN-1:0]  w_flip;
  logic [FIFO_SIZE-1:0] w_after_wr;
  logic [FIFO_SIZE-1:0] w_nvalid;
  logic [FIFO_SIZE-1:0] w_alloc;
  logic                 w_match;
  logic                 w_found;
  logic                 w_drop;
  logic [CNT_W-1:0]     w_ncount;

  always_comb begin
    w_rel      = verinject__injector_state - P_START;
    w_hit      = (verinject__injector_state >= P_START) && (w_rel < SPAN);
    w_hit_word = ADDR_W'(MEM_START + w_rel / WORD_LEN);
    w_hit_bit  = BIT_W'(w_rel % WORD_LEN);
  end

  // Read path: stored faults OR together, the current-cycle injection XORs on top
  // so a second flip of a stored bit cancels already in its hit cycle.
  always_comb begin
    w_flip = '0;
    for (int unsigned s = 0; s < FIFO_SIZE; s++) begin
      for (int unsigned j = 0; j < WORD_LEN; j++) begin
        if (r_valid[s] && (r_word[s] == read_address) && (r_bit[s] == BIT_W'(j)))
          w_flip[j] = 1'b1;
      end
    end
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      if (w_hit && (w_hit_word == read_address) && (w_hit_bit == BIT_W'(j)))
        w_flip[j] = ~w_flip[j];
    end
    modified = unmodified;
    for (int unsigned j = 0; j < WORD_LEN; j++)
      modified[BITS_START + j] = unmodified[BITS_START + j] ^ w_flip[j];
  end

  // Slot update: write retirement first, so a same-cycle injection lands after it.
  always_comb begin
    w_after_wr = r_valid;
    for (int unsigned s = 0; s < FIFO_SIZE; s++) begin
      if (do_write && (r_word[s] == write_address))
        w_after_wr[s] = 1'b0;
    end
    w_nvalid = w_after_wr;
    w_match  = 1'b0;
    for (int unsigned s = 0; s < FIFO_SIZE; s++) begin
      if (w_hit && w_after_wr[s] && (r_word[s] == w_hit_word) && (r_bit[s] == w_hit_bit)) begin
        w_nvalid[s] = 1'b0;
        w_match     = 1'b1;
      end
    end
    w_alloc = '0;
    w_found = 1'b0;
    for (int unsigned s = 0; s < FIFO_SIZE; s++) begin
      if (w_hit && !w_match && !w_found && !w_after_wr[s]) begin
        w_alloc[s]  = 1'b1;
        w_nvalid[s] = 1'b1;
        w_found     = 1'b1;
      end
    end
    w_drop   = w_hit && !w_match && !w_found;
    w_ncount = '0;
    for (int unsigned s = 0; s < FIFO_SIZE; s++)
      w_ncount = w_ncount + CNT_W'(w_nvalid[s]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_nvalid;
      r_count <= w_ncount;
      if (w_drop)
        r_overflow <= 1'b1;
      for (int unsigned s = 0; s < FIFO_SIZE; s++) begin
        if (w_alloc[s]) begin
          r_word[s] <= w_hit_word;
          r_bit[s]  <= w_hit_bit;
        end
      end
    end
  end

  assign fault_count = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_verinject_mem1_fault_tracker.sv
// Bench for verinject_mem1_fault_tracker: directed vector table plus randomized
// traffic checked against a set-based reference model.
module tb_verinject_mem1_fault_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] state;
  logic [7:0]  unmod;
  logic [3:0]  raddr;
  logic [7:0]  mod;
  logic        we;
  logic [3:0]  waddr;
  logic [2:0]  cnt;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  verinject_mem1_fault_tracker #(
    .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0),
    .MEM_LEFT(0), .MEM_RIGHT(15), .P_START(100), .FIFO_SIZE(4)
  ) dut (
    .clock(clk), .reset(rst), .verinject__injector_state(state),
    .unmodified(unmod), .read_address(raddr), .modified(mod),
    .do_write(we), .write_address(waddr), .fault_count(cnt), .overflow(ovf)
  );

  typedef struct {
    bit          rst;
    logic [31:0] state;
    logic [3:0]  ra;
    logic [7:0]  un;
    bit          we;
    logic [3:0]  wa;
    bit          chk;
    logic [7:0]  emod;
    logic [2:0]  ecnt;
    bit          eovf;
  } vec_t;

  typedef struct {
    int word;
    int bitpos;
  } fault_t;

  vec_t   tbl[$];
  fault_t faults[$];
  bit     m_ovf;

  function automatic vec_t mk(bit r, int st, int ra, int un, bit w, int wa,
                              bit chk, int emod, int ecnt, bit eovf);
    vec_t v;
    v.rst = r; v.state = st; v.ra = 4'(ra); v.un = 8'(un); v.we = w; v.wa = 4'(wa);
    v.chk = chk; v.emod = 8'(emod); v.ecnt = 3'(ecnt); v.eovf = eovf;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, logic [31:0] st, logic [3:0] ra, logic [7:0] un, bit w, logic [3:0] wa);
    @(negedge clk);
    rst = r; state = st; raddr = ra; unmod = un; we = w; waddr = wa;
    #1;
  endtask

  // Reference: the set of live faults; slot placement is not observable.
  function automatic logic [7:0] model_read(logic [31:0] st, int ra, logic [7:0] un);
    logic [7:0] m = '0;
    foreach (faults[i])
      if (faults[i].word == ra) m[faults[i].bitpos] = 1'b1;
    if (st >= 100 && st < 228 && int'((st - 100) / 8) == ra)
      m[(st - 100) % 8] = ~m[(st - 100) % 8];
    return un ^ m;
  endfunction

  task automatic model_step(bit r, logic [31:0] st, bit w, int wa);
    int  word, b;
    bit  found;
    if (r) begin
      faults.delete();
      m_ovf = 1'b0;
      return;
    end
    if (w)
      for (int i = faults.size() - 1; i >= 0; i--)
        if (faults[i].word == wa) faults.delete(i);
    if (st >= 100 && st < 228) begin
      word  = int'((st - 100) / 8);
      b     = int'((st - 100) % 8);
      found = 1'b0;
      for (int i = faults.size() - 1; i >= 0; i--)
        if (faults[i].word == word && faults[i].bitpos == b) begin
          faults.delete(i);
          found = 1'b1;
        end
      if (!found) begin
        if (faults.size() < 4) faults.push_back('{word, b});
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; state = '0; raddr = '0; unmod = '0; we = 1'b0; waddr = '0;

    //            rst st   ra un    we wa chk emod cnt ovf
    tbl.push_back(mk(1, 0,   0, 'h55, 0, 0, 0, 'h00, 0, 0));
    tbl.push_back(mk(0, 129, 3, 'h00, 0, 0, 1, 'h20, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 0, 0, 1, 'h20, 1, 0));
    tbl.push_back(mk(0, 0,   4, 'h00, 0, 0, 1, 'h00, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'hFF, 0, 0, 1, 'hDF, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 1, 2, 1, 'h20, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 0, 0, 1, 'h20, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 1, 3, 1, 'h20, 0, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 0, 0, 1, 'h00, 0, 0));
    tbl.push_back(mk(0, 129, 3, 'h00, 0, 0, 1, 'h20, 1, 0));
    tbl.push_back(mk(0, 129, 3, 'h00, 0, 0, 1, 'h00, 0, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 0, 0, 1, 'h00, 0, 0));
    tbl.push_back(mk(0, 129, 3, 'h00, 0, 0, 1, 'h20, 1, 0));
    tbl.push_back(mk(0, 130, 3, 'h00, 1, 3, 1, 'h60, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 0, 0, 1, 'h40, 1, 0));
    tbl.push_back(mk(0, 0,   3, 'h00, 1, 3, 1, 'h40, 0, 0));
    tbl.push_back(mk(0, 99,  0, 'h00, 0, 0, 1, 'h00, 0, 0));
    tbl.push_back(mk(0, 228, 15,'h00, 0, 0, 1, 'h00, 0, 0));
    tbl.push_back(mk(0, 227, 15,'h00, 0, 0, 1, 'h80, 1, 0));
    tbl.push_back(mk(0, 0,   15,'h00, 0, 0, 1, 'h80, 1, 0));
    tbl.push_back(mk(1, 129, 15,'h00, 1, 15,1, 'h80, 0, 0));
    tbl.push_back(mk(0, 0,   15,'h00, 0, 0, 1, 'h00, 0, 0));
    tbl.push_back(mk(0, 100, 0, 'hFF, 0, 0, 1, 'hFE, 1, 0));
    tbl.push_back(mk(0, 109, 1, 'h00, 0, 0, 1, 'h02, 2, 0));
    tbl.push_back(mk(0, 118, 2, 'h00, 0, 0, 1, 'h04, 3, 0));
    tbl.push_back(mk(0, 127, 3, 'h00, 0, 0, 1, 'h08, 4, 0));
    tbl.push_back(mk(0, 136, 0, 'hFF, 0, 0, 1, 'hFE, 4, 1));
    tbl.push_back(mk(0, 0,   4, 'h00, 0, 0, 1, 'h00, 4, 1));
    tbl.push_back(mk(0, 0,   0, 'hFF, 0, 0, 1, 'hFE, 4, 1));
    tbl.push_back(mk(0, 0,   1, 'h00, 1, 0, 1, 'h02, 3, 1));
    tbl.push_back(mk(1, 0,   0, 'h00, 0, 0, 1, 'h00, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].state, tbl[i].ra, tbl[i].un, tbl[i].we, tbl[i].wa);
      if (tbl[i].chk) check($sformatf("vec%0d modified", i), 32'(mod), 32'(tbl[i].emod));
      @(posedge clk); #1;
      check($sformatf("vec%0d fault_count", i), 32'(cnt), 32'(tbl[i].ecnt));
      check($sformatf("vec%0d overflow", i), 32'(ovf), 32'(tbl[i].eovf));
    end

    // Randomized traffic against the reference model; DUT was just reset.
    faults.delete();
    m_ovf = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit          r;
      bit          w;
      logic [31:0] st;
      logic [3:0]  ra, wa;
      logic [7:0]  un;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(95, 232));
      ra = 4'($urandom_range(0, 15));
      wa = 4'($urandom_range(0, 15));
      un = 8'($urandom);
      drive(r, st, ra, un, w, wa);
      if (n > 0) check("rand modified", 32'(mod), 32'(model_read(st, ra, un)));
      model_step(r, st, w, int'(wa));
      @(posedge clk); #1;
      check("rand fault_count", 32'(cnt), 32'(faults.size()));
      check("rand overflow", 32'(ovf), 32'(m_ovf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
